// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int OFS_TX_DATA = 0;
    localparam int OFS_STATUS  = 1;

    localparam int ST_BUSY  = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_EMPTY = 4;

    function automatic logic [15:0] status_word(input logic empty, input logic ovf,
                                                input logic full, input logic busy);
        logic [15:0] w;
        w           = '0;
        w[ST_EMPTY] = empty;
        w[ST_OVF]   = ovf;
        w[ST_FULL]  = full;
        w[ST_BUSY]  = busy;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with extra-MSB pointers; a pop while full frees
// the slot so a same-edge push is still accepted. No fall-through.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: decodes TX_DATA/STATUS in the data
// address space, buffers stores in a FIFO and shifts bytes out on tx.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [9:0] BASE_ADDR    = 10'h3F0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_we,
    output logic        io_hit,
    output logic [15:0] io_rdata,
    output logic        tx,
    output logic        irq_empty
);

    localparam int          CW          = $clog2(FIFO_DEPTH);
    localparam logic [9:0]  DATA_ADDR   = BASE_ADDR + 10'(OFS_TX_DATA);
    localparam logic [9:0]  STATUS_ADDR = BASE_ADDR + 10'(OFS_STATUS);
    localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);

    uart_state_t state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_d;
    logic        ovf_q;

    logic        hit_data, hit_status, push_req;
    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [CW:0] fifo_count;
    logic        busy;
    logic        baud_last;

    // Upper store-data byte has no meaning for an 8-bit transmitter.
    logic unused_wdata;
    assign unused_wdata = ^cpu_wdata[15:8];

    assign hit_data   = (cpu_addr == DATA_ADDR);
    assign hit_status = (cpu_addr == STATUS_ADDR);
    assign push_req   = cpu_we && hit_data;
    assign busy       = (state_q != IDLE);
    assign irq_empty  = (fifo_count == '0) && (state_q == IDLE);
    assign baud_last  = (baud_q == BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data (cpu_wdata[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + 16'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the next-state view so the line changes on the edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx       <= 1'b1;
            ovf_q    <= 1'b0;
            io_hit   <= 1'b0;
            io_rdata <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx       <= tx_d;
            io_hit   <= hit_data || hit_status;
            io_rdata <= hit_status ? status_word(fifo_count == '0, ovf_q, fifo_full, busy) : '0;
            if (cpu_we && hit_status)
                ovf_q <= 1'b0;
            else if (push_req && fifo_full && !fifo_pop)
                ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected frames and
// read data; independent monitors decode tx and io_hit/io_rdata.
module tb_mmio_uart_tx;

    localparam int CPB       = 4;
    localparam int DEPTH     = 8;
    localparam int FRAME_CYC = 10 * CPB;

    logic        clock;
    logic        reset;
    logic [9:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic        io_hit;
    logic [15:0] io_rdata;
    logic        tx;
    logic        irq_empty;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  exp_tx_q[$];
    logic [15:0] exp_rd_q[$];

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .BASE_ADDR    (10'h3F0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .io_hit    (io_hit),
        .io_rdata  (io_rdata),
        .tx        (tx),
        .irq_empty (irq_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [FRAME_CYC-1:0] frame_bits(input logic [7:0] b);
        logic [FRAME_CYC-1:0] f;
        for (int c = 0; c < FRAME_CYC; c++) begin
            int pos;
            pos = c / CPB;
            if (pos == 0)      f[c] = 1'b0;
            else if (pos == 9) f[c] = 1'b1;
            else               f[c] = b[pos-1];
        end
        return f;
    endfunction

    // One bus cycle; the read expectation is queued once the access has been sampled.
    task automatic bus(input logic [9:0] a, input logic [15:0] d, input logic we,
                       input logic [15:0] exp_rd);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = we;
        @(posedge clock);
        #1;
        cpu_we    = 1'b0;
        cpu_addr  = 10'h000;
        cpu_wdata = 16'h0000;
        if (a == 10'h3F0 || a == 10'h3F1) exp_rd_q.push_back(exp_rd);
    endtask

    task automatic store_byte(input logic [15:0] d, input logic expect_sent);
        bus(10'h3F0, d, 1'b1, 16'h0000);
        if (expect_sent) exp_tx_q.push_back(d[7:0]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Read-data monitor.
    initial begin : rd_monitor
        forever begin
            @(negedge clock);
            if (io_hit === 1'b1) begin
                if (exp_rd_q.size() == 0) check("unexpected_io_hit", 1, 0);
                else                      check("io_rdata", io_rdata, exp_rd_q.pop_front());
            end else if (exp_rd_q.size() != 0) begin
                check("io_hit_missing", io_hit, 1);
                void'(exp_rd_q.pop_front());
            end
        end
    end

    // Serial line monitor: captures each frame cycle by cycle.
    initial begin : tx_monitor
        logic [FRAME_CYC-1:0] got;
        logic                 aborted;
        forever begin
            @(negedge clock);
            if (reset !== 1'b0 || tx !== 1'b0) continue;
            aborted = 1'b0;
            got[0]  = tx;
            for (int c = 1; c < FRAME_CYC; c++) begin
                @(negedge clock);
                if (reset !== 1'b0) begin
                    aborted = 1'b1;
                    break;
                end
                got[c] = tx;
            end
            if (aborted) continue;
            if (exp_tx_q.size() == 0) check("unexpected_frame", got, 0);
            else                      check("tx_frame", got, frame_bits(exp_tx_q.pop_front()));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int waited;
        reset     = 1'b1;
        cpu_addr  = 10'h000;
        cpu_wdata = 16'h0000;
        cpu_we    = 1'b0;
        idle(2);
        reset = 1'b0;

        // Reset state.
        check("reset_tx", tx, 1);
        check("reset_io_hit", io_hit, 0);
        check("reset_io_rdata", io_rdata, 0);
        check("reset_irq_empty", irq_empty, 1);
        bus(10'h3F1, 16'h0000, 1'b0, 16'h0010);

        // Single byte 0x55; upper data byte must be ignored.
        store_byte(16'hAB55, 1'b1);
        check("single_tx_before_pop", tx, 1);
        idle(1);
        check("single_first_low", tx, 0);
        check("single_irq_busy", irq_empty, 0);
        idle(39);
        check("single_irq_last_cycle", irq_empty, 0);
        idle(1);
        check("single_irq_after_frame", irq_empty, 1);

        // Back-to-back frames.
        store_byte(16'hFF01, 1'b1);
        store_byte(16'hEE02, 1'b1);
        store_byte(16'hDD03, 1'b1);
        idle(38);
        check("b2b_stop1", tx, 1);
        idle(1);
        check("b2b_start2_no_gap", tx, 0);
        idle(11);
        bus(10'h3F1, 16'h0000, 1'b0, 16'h0002);
        idle(27);
        check("b2b_stop2", tx, 1);
        idle(1);
        check("b2b_start3_no_gap", tx, 0);
        idle(39);
        check("b2b_irq_last_cycle", irq_empty, 0);
        idle(1);
        check("b2b_irq_after_120", irq_empty, 1);

        // Overflow: 10 consecutive stores, 9 accepted.
        for (int i = 0; i < 10; i++)
            store_byte(16'h5A00 | 16'(8'hA0 + i), i < 9);
        bus(10'h3F1, 16'h0000, 1'b0, 16'h000E);
        bus(10'h3F1, 16'h1234, 1'b1, 16'h000E);
        bus(10'h3F1, 16'h0000, 1'b0, 16'h0006);
        waited = 0;
        while ((irq_empty !== 1'b1 || exp_tx_q.size() != 0) && waited < 600) begin
            idle(1);
            waited++;
        end
        check("ovf_drain_timeout", waited < 600, 1);
        bus(10'h3F1, 16'h0000, 1'b0, 16'h0010);

        // Decode: out-of-window accesses are ignored.
        bus(10'h3F1, 16'h0000, 1'b0, 16'h0010);
        check("decode_status_hit", io_hit, 1);
        bus(10'h3F2, 16'h0000, 1'b0, 16'h0000);
        check("decode_3f2_no_hit", io_hit, 0);
        bus(10'h100, 16'h00C3, 1'b1, 16'h0000);
        check("decode_100_no_hit", io_hit, 0);
        bus(10'h3F1, 16'h0000, 1'b0, 16'h0010);
        check("decode_irq_still_empty", irq_empty, 1);
        idle(50);
        check("decode_tx_idle", tx, 1);

        // Reset during DATA bit 3 with 4 bytes queued; nothing may be sent.
        for (int i = 0; i < 5; i++)
            store_byte(16'h00C1 + 16'(i), 1'b0);
        idle(14);
        reset = 1'b1;
        idle(1);
        check("midreset_tx_high", tx, 1);
        check("midreset_io_hit", io_hit, 0);
        check("midreset_irq_empty", irq_empty, 1);
        reset = 1'b0;
        bus(10'h3F1, 16'h0000, 1'b0, 16'h0010);
        idle(100);
        check("midreset_irq_after", irq_empty, 1);

        idle(2);
        check("tx_queue_drained", exp_tx_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
